// File: rtl/udp_fragment_slot_pkg.sv
// -----------------------------------------------------------------------------
// udp_package
// Shared definitions for the UDP fragment reassembly slot.
//   slot_state_t           : slot life cycle (empty -> filling -> complete ->
//                            draining -> empty)
//   TIMEOUT_LIMIT_DEFAULT  : default idle-cycle budget while filling
// Related build macro: UDP_FRAGMENT_SLOT_TIMEOUT_EN (used by udp_fragment_slot).
// -----------------------------------------------------------------------------
package udp_package;

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_FILLING  = 2'd1,
        S_COMPLETE = 2'd2,
        S_DRAINING = 2'd3
    } slot_state_t;

    localparam logic [15:0] TIMEOUT_LIMIT_DEFAULT = 16'h0FFF;

endpackage

// File: rtl/udp_fragment_slot_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Counts consecutive running cycles without a reload and flags the cycle on
// which the LIMIT-th such cycle occurs.
// Ports:
//   clock    in   sole clock
//   reset_n  in   asynchronous active-low reset
//   reload   in   restart the count (activity seen this cycle)
//   run      in   timer is armed; count is held at zero while low
//   expired  out  this is the LIMIT-th consecutive idle running cycle
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = LIMIT - WIDTH'(1);

    logic [WIDTH-1:0] count;

    assign expired = run && !reload && (count == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (reload || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/udp_fragment_slot.sv
// -----------------------------------------------------------------------------
// udp_fragment_slot
// One reassembly slot: buffers the bytes of a single datagram pushed by the
// receive handler, then streams them out to a consumer with valid/ready.
// Build macro: UDP_FRAGMENT_SLOT_TIMEOUT_EN -- when defined, a slot left idle
// for TIMEOUT_LIMIT cycles while filling is abandoned with an error pulse.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   push_data/_valid/_last    byte stream from the handler (last may be alone)
//   packet_id                 IPv4 identification, captured on the first byte
//   push_data_enable          slot can take a byte this cycle
//   fragment_slot_empty       slot holds no datagram
//   fragment_slot_packet_id   identification of the held datagram
//   read_data/_valid/_last    reassembled byte stream to the consumer
//   read_ready                consumer accepts read_data
//   byte_count                number of bytes stored
//   error                     one-cycle pulse: overflow, timeout, or a push
//                             while complete/draining
// -----------------------------------------------------------------------------
module udp_fragment_slot
    import udp_package::*;
#(
    parameter int          DEPTH         = 2048,
    parameter logic [15:0] TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             push_data,
    input  logic                   push_data_valid,
    input  logic                   push_data_last,
    input  logic [15:0]            packet_id,
    output logic                   push_data_enable,
    output logic                   fragment_slot_empty,
    output logic [15:0]            fragment_slot_packet_id,
    output logic [7:0]             read_data,
    output logic                   read_valid,
    output logic                   read_last,
    input  logic                   read_ready,
    output logic [$clog2(DEPTH):0] byte_count,
    output logic                   error
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);

    slot_state_t   state;
    logic          alive;      // low during reset and until the first edge after it
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [7:0]    mem [DEPTH];

    logic          has_room;
    logic          wr_en;
    logic          xfer;
    logic          timeout;

    assign has_room  = byte_count < DEPTH_CNT;
    // Only the empty and filling states store bytes; anything else is an error.
    assign wr_en     = push_data_valid &&
                       ((state == S_EMPTY) || ((state == S_FILLING) && has_room));
    assign xfer      = read_valid && read_ready;
    assign rd_next   = rd_ptr + AW'(1);

    assign push_data_enable    = alive &&
                                 ((state == S_EMPTY) || ((state == S_FILLING) && has_room));
    assign fragment_slot_empty = (state == S_EMPTY);

    // Buffer RAM: write port from the handler, read port feeds read_data.
    // byte_count is zero in S_EMPTY, so it doubles as the write address.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[byte_count[AW-1:0]] <= push_data;
        end
    end

`ifdef UDP_FRAGMENT_SLOT_TIMEOUT_EN
    // Every accepted byte reloads the timer, including the one that enters
    // S_FILLING from S_EMPTY.
    cycle_timer #(
        .WIDTH (16),
        .LIMIT (TIMEOUT_LIMIT)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .reload  (wr_en),
        .run     (state == S_FILLING),
        .expired (timeout)
    );
`else
    logic unused_timeout_limit;
    assign unused_timeout_limit = ^TIMEOUT_LIMIT;
    assign timeout              = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= S_EMPTY;
            alive                   <= 1'b0;
            byte_count              <= '0;
            rd_ptr                  <= '0;
            fragment_slot_packet_id <= '0;
            read_data               <= '0;
            read_valid              <= 1'b0;
            read_last               <= 1'b0;
            error                   <= 1'b0;
        end else begin
            alive <= 1'b1;
            error <= 1'b0;
            case (state)
                S_EMPTY: begin
                    // A lone last with no byte is ignored here.
                    if (push_data_valid) begin
                        fragment_slot_packet_id <= packet_id;
                        byte_count              <= ONE_CNT;
                        state <= push_data_last ? S_COMPLETE : S_FILLING;
                    end
                end
                S_FILLING: begin
                    if (push_data_valid && !has_room) begin
                        // Overflow: drop the datagram entirely.
                        error      <= 1'b1;
                        byte_count <= '0;
                        state      <= S_EMPTY;
                    end else begin
                        if (push_data_valid) begin
                            byte_count <= byte_count + ONE_CNT;
                        end
                        if (push_data_last) begin
                            state <= S_COMPLETE;
                        end else if (timeout) begin
                            error      <= 1'b1;
                            byte_count <= '0;
                            state      <= S_EMPTY;
                        end
                    end
                end
                S_COMPLETE: begin
                    if (push_data_valid) begin
                        error <= 1'b1;
                    end
                    read_data  <= mem['0];
                    rd_ptr     <= '0;
                    read_valid <= 1'b1;
                    read_last  <= (byte_count == ONE_CNT);
                    state      <= S_DRAINING;
                end
                S_DRAINING: begin
                    if (push_data_valid) begin
                        error <= 1'b1;
                    end
                    if (xfer) begin
                        if (read_last) begin
                            read_valid <= 1'b0;
                            read_last  <= 1'b0;
                            byte_count <= '0;
                            state      <= S_EMPTY;
                        end else begin
                            // Fetch the next byte on the transfer edge so the
                            // stream has no bubbles.
                            rd_ptr    <= rd_next;
                            read_data <= mem[rd_next];
                            read_last <= ({1'b0, rd_next} == (byte_count - ONE_CNT));
                        end
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/udp_fragment_slot.md
UDP_FRAGMENT_SLOT -- requirements
Module: udp_fragment_slot

Interface
REQ-001 Parameter DEPTH, default 2048: payload bytes the slot buffers; power of two.
REQ-002 Parameter TIMEOUT_LIMIT, default 16'h0FFF: idle cycles allowed while filling before abandon.
REQ-003 clock  in  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 push_data  in  8  byte from the receive handler.
REQ-006 push_data_valid  in  1  this slot's bit of the handler's one-hot valid vector.
REQ-007 push_data_last  in  1  this slot's bit of the handler's last vector; may arrive with or without valid.
REQ-008 packet_id  in  16  IPv4 identification from the handler; sampled on the first accepted byte.
REQ-009 push_data_enable  out  1  slot can accept a byte this cycle.
REQ-010 fragment_slot_empty  out  1  slot holds no datagram.
REQ-011 fragment_slot_packet_id  out  16  identification of the datagram held.
REQ-012 read_data  out  8  reassembled byte to the consumer.
REQ-013 read_valid  out  1  read_data is valid.
REQ-014 read_last  out  1  read_data is the final byte.
REQ-015 read_ready  in  1  consumer accepts read_data.
REQ-016 byte_count  out  $clog2(DEPTH)+1  bytes stored.
REQ-017 error  out  1  one-cycle pulse on overflow, timeout abandon or push in a non-filling state.

Function
REQ-018 States: S_EMPTY, S_FILLING, S_COMPLETE, S_DRAINING.
REQ-019 S_EMPTY: fragment_slot_empty=1 and push_data_enable=1. A valid byte is written at address 0, packet_id is latched, byte_count becomes 1, and the state moves to S_FILLING.
REQ-020 S_FILLING: each valid byte is written at address byte_count and byte_count increments. push_data_enable = (byte_count < DEPTH).
REQ-021 Last seen in S_FILLING, with or without a byte (that byte is stored first): the state moves to S_COMPLETE.
REQ-022 Last seen in S_EMPTY without valid: ignored, no state change.
REQ-023 Last together with valid in S_EMPTY: the byte is stored and the state moves to S_COMPLETE with byte_count=1.
REQ-024 Valid while byte_count==DEPTH: the byte is dropped, error pulses, byte_count clears and the state returns to S_EMPTY.
REQ-025 Valid in S_COMPLETE or S_DRAINING: the byte is dropped, error pulses and the state is unchanged.
REQ-026 S_COMPLETE: after one cycle, read_data is loaded from address 0, read_valid=1 and the state moves to S_DRAINING. The first byte is therefore presented 2 cycles after the last push.
REQ-027 S_DRAINING: each read_valid&&read_ready transfer advances the read pointer and presents the next byte on the next cycle (zero bubbles). read_last=1 when read pointer == byte_count-1.
REQ-028 Transfer with read_last=1: on the next cycle read_valid=0, byte_count=0, fragment_slot_empty=1 and the state returns to S_EMPTY.
REQ-029 read_data and read_valid hold stable while read_valid=1 and read_ready=0.
REQ-030 fragment_slot_empty=0 in every state except S_EMPTY.
REQ-031 fragment_slot_packet_id holds the latched value until the next S_EMPTY capture.
REQ-032 Pointers and byte_count are unsigned and never wrap. Overflow is handled per REQ-024.

Reset
REQ-033 Reset mid-operation discards all contents and returns the slot to S_EMPTY.
REQ-034 Output reset values: push_data_enable=0 during reset and 1 on the first cycle after; fragment_slot_empty=1; fragment_slot_packet_id=0; read_data=0; read_valid=0; read_last=0; byte_count=0; error=0.
REQ-035 Buffer RAM contents are not reset.

Configuration
REQ-036 Macro UDP_FRAGMENT_SLOT_TIMEOUT_EN defined: in S_FILLING, TIMEOUT_LIMIT consecutive cycles without a push cause abandon to S_EMPTY with an error pulse. The counter reloads on every accepted byte and on S_FILLING entry.
REQ-037 Macro undefined: no timer is instantiated and S_FILLING is held indefinitely.

Structure
REQ-038 The state enum and the default TIMEOUT_LIMIT constant live in shared package udp_package.
REQ-039 The existing cycle_timer is the only sub-module. It is instantiated only under UDP_FRAGMENT_SLOT_TIMEOUT_EN.
REQ-040 The buffer is an inferred simple dual-port RAM, DEPTH x 8.

Verification
REQ-041 Reset; push 4 bytes 0x11,0x22,0x33,0x44 with last on 0x44 and packet_id=0xBEEF; read_ready=1 -> fragment_slot_packet_id=0xBEEF, fragment_slot_empty=0 from the first push, first read_valid 2 cycles after the last push, bytes 11,22,33,44 on consecutive cycles, read_last on 44, fragment_slot_empty=1 on the next cycle.
REQ-042 Push 3 bytes, then last alone; toggle read_ready 1,0,1,0 -> byte_count=3; data is held during stalls; exactly 3 transfers occur.
REQ-043 DEPTH=8; push 9 bytes -> push_data_enable=0 after the 8th byte; error pulses on the 9th; slot returns to empty.
REQ-044 Push during S_DRAINING -> error pulse; drained data unchanged.
REQ-045 With UDP_FRAGMENT_SLOT_TIMEOUT_EN and TIMEOUT_LIMIT=16: push 2 bytes then idle -> error pulse and empty within 16+2 cycles. Same stimulus without the macro -> slot remains in S_FILLING.
REQ-046 Assert reset_n low mid-drain -> all outputs take reset values immediately; a subsequent 1-byte datagram drains correctly.
